calc_pb_player: RTL and testbench

- Drives the calculator's pushbutton bus instead of a human.
- Host-pushed command FIFO: each command is a 10-bit button mask plus a hold length.
- Plays each command as a timed press, a release gap and a settle wait, then captures the calculator's 14-bit seven-segment output.
- Sits between a test/host controller and the calculator top: pb out to the calculator, ss back in. Used for scripted bring-up and regression on silicon.

---
 rtl/calc_pb_player_pkg.sv | 31 +++
 rtl/pb_cmd_fifo.sv | 54 +++++
 rtl/calc_pb_player.sv | 130 +++++++++++++
 tb/tb_calc_pb_player.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pb_player_pkg.sv
// Shared types and field layout for the calculator pushbutton player.
// A command word is {hold[3:0], buttons[9:0]}.
package calc_pb_player_pkg;

  localparam int CMD_W    = 14;
  localparam int PB_W     = 10;
  localparam int HOLD_W   = 4;
  localparam int SS_W     = 14;

  localparam int BTN_LSB  = 0;
  localparam int BTN_MSB  = PB_W - 1;
  localparam int HOLD_LSB = PB_W;
  localparam int HOLD_MSB = PB_W + HOLD_W - 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRESS   = 3'd1,
    ST_RELEASE = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_CAPTURE = 3'd4
  } player_state_t;

  function automatic logic [PB_W-1:0] cmd_buttons(input logic [CMD_W-1:0] cmd);
    return cmd[BTN_MSB:BTN_LSB];
  endfunction

  function automatic logic [HOLD_W-1:0] cmd_hold(input logic [CMD_W-1:0] cmd);
    return cmd[HOLD_MSB:HOLD_LSB];
  endfunction

endpackage

// File: rtl/pb_cmd_fifo.sv
// Synchronous command FIFO. Full/empty derive from the registered level only;
// read data comes straight from the storage registers at the read pointer.
module pb_cmd_fifo
  import calc_pb_player_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [CMD_W-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [CMD_W-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [CMD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rd_ptr];

  // A push while full is dropped even if a pop frees a slot this cycle.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (!nrst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && nrst && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/calc_pb_player.sv
// Plays queued button commands into the calculator as press/release/settle
// sequences and captures the seven-segment display after each one.
module calc_pb_player
  import calc_pb_player_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int GAP    = 4,
  parameter int SETTLE = 2
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [CMD_W-1:0]        cmd_data,
  input  logic                    start,
  input  logic                    abort,
  output logic [PB_W-1:0]         pb,
  input  logic [SS_W-1:0]         ss,
  output logic [SS_W-1:0]         cap_ss,
  output logic                    cap_valid,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  level,
  output player_state_t           dbg_state
);

  localparam int HOLD_MAX  = (1 << HOLD_W) - 1;
  localparam int CNT_MAX_A = ((GAP - 1) > HOLD_MAX) ? (GAP - 1) : HOLD_MAX;
  localparam int CNT_MAX   = ((SETTLE - 1) > CNT_MAX_A) ? (SETTLE - 1) : CNT_MAX_A;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  player_state_t    r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CMD_W-1:0] r_cmd;
  logic [SS_W-1:0]  r_cap_ss;
  logic             r_cap_valid;

  logic [CMD_W-1:0] w_rdata;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  // Handshake: a command transfers on a cycle where cmd_valid and cmd_ready are
  // both high; cmd_ready depends only on registered occupancy, never on cmd_valid.
  assign w_push = cmd_valid & ~abort;
  assign w_pop  = ~abort & ((r_state == ST_IDLE && start) || (r_state == ST_CAPTURE));

  pb_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .nrst    (nrst),
    .i_flush (abort),
    .i_push  (w_push),
    .i_wdata (cmd_data),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  assign cmd_ready = ~w_full;
  assign busy      = (r_state != ST_IDLE);
  assign cap_ss    = r_cap_ss;
  assign cap_valid = r_cap_valid;
  assign dbg_state = r_state;

  always_comb begin
    pb = '0;
    if (r_state == ST_PRESS) pb = cmd_buttons(r_cmd);
  end

  // Each timed phase loads r_cnt with (length - 1) on entry and leaves at zero.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_cmd       <= '0;
      r_cap_ss    <= '0;
      r_cap_valid <= 1'b0;
    end else if (abort) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_cap_valid <= 1'b0;
    end else begin
      r_cap_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && !w_empty) begin
            r_cmd   <= w_rdata;
            r_cnt   <= CNT_W'(cmd_hold(w_rdata));
            r_state <= ST_PRESS;
          end
        end
        ST_PRESS: begin
          if (r_cnt == '0) begin
            r_cnt   <= CNT_W'(GAP - 1);
            r_state <= ST_RELEASE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RELEASE: begin
          if (r_cnt == '0) begin
            r_cnt   <= CNT_W'(SETTLE - 1);
            r_state <= ST_SETTLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_SETTLE: begin
          if (r_cnt == '0) r_state <= ST_CAPTURE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        ST_CAPTURE: begin
          r_cap_ss    <= ss;
          r_cap_valid <= 1'b1;
          if (!w_empty) begin
            r_cmd   <= w_rdata;
            r_cnt   <= CNT_W'(cmd_hold(w_rdata));
            r_state <= ST_PRESS;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_pb_player.sv
// Directed bench for calc_pb_player: playback timing, FIFO limits, abort, reset.
module tb_calc_pb_player;
  import calc_pb_player_pkg::*;

  localparam int DEPTH  = 8;
  localparam int GAP    = 4;
  localparam int SETTLE = 2;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            nrst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [13:0]     cmd_data;
  logic            start;
  logic            abort;
  logic [9:0]      pb;
  logic [13:0]     ss;
  logic [13:0]     cap_ss;
  logic            cap_valid;
  logic            busy;
  logic [LW-1:0]   level;
  player_state_t   dbg_state;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          seq_hold [8];
  logic [9:0]  seq_mask [8];
  logic [13:0] m_cap_ss;

  always #5 clk = ~clk;

  calc_pb_player #(.DEPTH(DEPTH), .GAP(GAP), .SETTLE(SETTLE)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .start     (start),
    .abort     (abort),
    .pb        (pb),
    .ss        (ss),
    .cap_ss    (cap_ss),
    .cap_valid (cap_valid),
    .busy      (busy),
    .level     (level),
    .dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] h, input logic [9:0] m);
    cmd_valid = 1'b1;
    cmd_data  = {h, m};
    tick();
    cmd_valid = 1'b0;
  endtask

  function automatic logic [13:0] ss_at(input int c);
    return 14'(c * 37 + 5);
  endfunction

  // Builds the expected cycle-by-cycle trace for n queued commands, then
  // pulses start (cycle 0) and compares cycles 1.. against it.
  task automatic run_seq(input int n);
    logic [9:0]  e_pb [$];
    logic        e_busy [$];
    logic        e_cv [$];
    logic [13:0] e_ss [$];
    logic        prev_cap;
    logic [13:0] ms;
    int          c;
    int          len;
    prev_cap = 1'b0;
    ms = m_cap_ss;
    c = 1;
    for (int i = 0; i < n; i++) begin
      len = seq_hold[i] + 1 + GAP + SETTLE + 1;
      for (int k = 0; k < len; k++) begin
        e_pb.push_back((k <= seq_hold[i]) ? seq_mask[i] : 10'h0);
        e_busy.push_back(1'b1);
        e_cv.push_back(prev_cap);
        e_ss.push_back(ms);
        prev_cap = (k == len - 1);
        if (prev_cap) ms = ss_at(c);
        c++;
      end
    end
    for (int k = 0; k < 2; k++) begin
      e_pb.push_back(10'h0);
      e_busy.push_back(1'b0);
      e_cv.push_back(prev_cap);
      e_ss.push_back(ms);
      prev_cap = 1'b0;
    end
    ss    = ss_at(0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cc = 1; cc <= e_pb.size(); cc++) begin
      ss = ss_at(cc);
      check($sformatf("pb c%0d", cc), pb, e_pb[cc-1]);
      check($sformatf("busy c%0d", cc), busy, e_busy[cc-1]);
      check($sformatf("cap_valid c%0d", cc), cap_valid, e_cv[cc-1]);
      check($sformatf("cap_ss c%0d", cc), cap_ss, e_ss[cc-1]);
      tick();
    end
    m_cap_ss = ms;
  endtask

  initial begin
    nrst = 1'b0; cmd_valid = 1'b0; cmd_data = '0; start = 1'b0; abort = 1'b0;
    ss = '0; m_cap_ss = '0;
    tick();
    tick();
    check("rst pb", pb, 0);
    check("rst cap_ss", cap_ss, 0);
    check("rst cap_valid", cap_valid, 0);
    check("rst busy", busy, 0);
    check("rst level", level, 0);
    check("rst cmd_ready", cmd_ready, 1);
    check("rst state", dbg_state, ST_IDLE);
    nrst = 1'b1;
    tick();

    // Single one-cycle press
    push(4'd0, 10'h010);
    seq_hold[0] = 0; seq_mask[0] = 10'h010;
    run_seq(1);

    // Three back-to-back commands from one start
    push(4'd2, 10'h001);
    push(4'd0, 10'h200);
    push(4'd15, 10'h3FF);
    seq_hold[0] = 2;  seq_mask[0] = 10'h001;
    seq_hold[1] = 0;  seq_mask[1] = 10'h200;
    seq_hold[2] = 15; seq_mask[2] = 10'h3FF;
    run_seq(3);

    // Zero-mask timed read
    push(4'd5, 10'h000);
    seq_hold[0] = 5; seq_mask[0] = 10'h000;
    run_seq(1);

    // Fill FIFO, overflow push, then start while full with a push offered
    for (int i = 0; i < DEPTH; i++) push(4'd0, 10'(i + 1));
    check("full level", level, DEPTH);
    check("full cmd_ready", cmd_ready, 0);
    push(4'd0, 10'h3AA);
    check("overflow level", level, DEPTH);
    start = 1'b1; cmd_valid = 1'b1; cmd_data = {4'd0, 10'h2AA};
    tick();
    start = 1'b0; cmd_valid = 1'b0;
    check("pop level", level, DEPTH - 1);
    check("pop cmd_ready", cmd_ready, 1);
    check("pop busy", busy, 1);
    check("pop pb head", pb, 10'h001);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("flush level", level, 0);
    check("flush busy", busy, 0);
    check("flush pb", pb, 0);
    check("flush cap_valid", cap_valid, 0);

    // Abort during RELEASE of the second of four commands
    push(4'd1, 10'h011);
    push(4'd1, 10'h022);
    push(4'd1, 10'h044);
    push(4'd1, 10'h088);
    ss = 14'h2BC;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cc = 1; cc <= 12; cc++) begin
      check($sformatf("ab pb c%0d", cc), pb,
            (cc <= 2) ? 10'h011 : ((cc == 10 || cc == 11) ? 10'h022 : 10'h000));
      check($sformatf("ab cap_valid c%0d", cc), cap_valid, (cc == 10) ? 1 : 0);
      check($sformatf("ab level c%0d", cc), level, 3);
      check($sformatf("ab busy c%0d", cc), busy, 1);
      if (cc == 9) begin cmd_valid = 1'b1; cmd_data = {4'd0, 10'h099}; end
      else         cmd_valid = 1'b0;
      tick();
    end
    check("ab cap_ss", cap_ss, 14'h2BC);
    m_cap_ss = 14'h2BC;
    abort = 1'b1; cmd_valid = 1'b1; cmd_data = {4'd0, 10'h123};
    tick();
    abort = 1'b0; cmd_valid = 1'b0;
    check("abort pb", pb, 0);
    check("abort busy", busy, 0);
    check("abort level", level, 0);
    check("abort cap_valid", cap_valid, 0);
    for (int cc = 0; cc < 12; cc++) begin
      check($sformatf("post-abort cap_valid %0d", cc), cap_valid, 0);
      tick();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    check("empty start busy", busy, 0);
    tick();
    check("empty start state", dbg_state, ST_IDLE);

    // Reset in the middle of PRESS
    push(4'd7, 10'h155);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("pre-rst pb", pb, 10'h155);
    check("pre-rst state", dbg_state, ST_PRESS);
    nrst = 1'b0;
    tick();
    check("mid rst pb", pb, 0);
    check("mid rst cap_ss", cap_ss, 0);
    check("mid rst level", level, 0);
    check("mid rst busy", busy, 0);
    check("mid rst cap_valid", cap_valid, 0);
    check("mid rst cmd_ready", cmd_ready, 1);
    nrst = 1'b1;
    m_cap_ss = '0;
    for (int cc = 0; cc < 16; cc++) begin
      check($sformatf("post-rst busy %0d", cc), busy, 0);
      check($sformatf("post-rst cap_valid %0d", cc), cap_valid, 0);
      tick();
    end
    check("post-rst pb", pb, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
